// File: rtl/prefix_add_pkg.sv
// rtl/prefix_add_pkg.sv - shared types, constants and prefix cells for the wide adder sequencer
package prefix_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  // Index counter width; a single-slice build still needs one bit.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // GP cell: {generate, propagate} of one bit.
  function automatic logic [1:0] gp_cell(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  // Black cell: combines two groups into {g, p}.
  function automatic logic [1:0] black_cell(input logic gh, input logic ph,
                                            input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

  // Gray cell: group generate only, used once the low group is anchored at cin.
  function automatic logic gray_cell(input logic gh, input logic ph, input logic gl);
    return gh | (ph & gl);
  endfunction

endpackage

// File: rtl/brent_kung8_cin.sv
// rtl/brent_kung8_cin.sv - 8-bit Brent-Kung prefix adder with carry-in
module brent_kung8_cin
  import prefix_add_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g, p;
  logic       g_0, g_1_0, g_2_0, g_3_0, g_4_0, g_5_0, g_6_0, g_7_0;
  logic       g_3_2, p_3_2, g_5_4, p_5_4, g_7_6, p_7_6, g_7_4, p_7_4;
  logic [7:0] c;

  for (genvar i = 0; i < 8; i++) begin : g_gp
    assign {g[i], p[i]} = gp_cell(a[i], b[i]);
  end

  // cin acts as generate at position -1 with zero propagate, so bit 0 is already a gray cell.
  assign g_0 = gray_cell(g[0], p[0], cin);

  // Up-sweep
  assign g_1_0          = gray_cell(g[1], p[1], g_0);
  assign {g_3_2, p_3_2} = black_cell(g[3], p[3], g[2], p[2]);
  assign {g_5_4, p_5_4} = black_cell(g[5], p[5], g[4], p[4]);
  assign {g_7_6, p_7_6} = black_cell(g[7], p[7], g[6], p[6]);
  assign g_3_0          = gray_cell(g_3_2, p_3_2, g_1_0);
  assign {g_7_4, p_7_4} = black_cell(g_7_6, p_7_6, g_5_4, p_5_4);
  assign g_7_0          = gray_cell(g_7_4, p_7_4, g_3_0);

  // Down-sweep fills in the remaining prefixes
  assign g_5_0 = gray_cell(g_5_4, p_5_4, g_3_0);
  assign g_2_0 = gray_cell(g[2], p[2], g_1_0);
  assign g_4_0 = gray_cell(g[4], p[4], g_3_0);
  assign g_6_0 = gray_cell(g[6], p[6], g_5_0);

  assign c    = {g_6_0, g_5_0, g_4_0, g_3_0, g_2_0, g_1_0, g_0, cin};
  assign sum  = p ^ c;
  assign cout = g_7_0;

endmodule

// File: rtl/prefix_add_seq.sv
// rtl/prefix_add_seq.sv - multi-cycle wide adder streaming 8-bit slices through one prefix adder
module prefix_add_seq
  import prefix_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     busy
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state;
  logic [W-1:0]       a_q, b_q, result;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout;

  assign sl_a = a_q[SLICE_W*int'(idx) +: SLICE_W];
  assign sl_b = b_q[SLICE_W*int'(idx) +: SLICE_W];

  brent_kung8_cin u_adder (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      carry       <= 1'b0;
      idx         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry      <= in_cin;
            idx        <= '0;
            result     <= '0;
            state      <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          result[SLICE_W*int'(idx) +: SLICE_W] <= sl_sum;
          carry <= sl_cout;
          // Index parks on the last slice; it is reloaded at the next accept.
          if (idx == LAST_IDX) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = result;
  assign out_cout  = carry;

endmodule
